// File: rtl/fetch_responder.sv
// fetch_responder: instruction-memory responder with fixed wait states and a program-load write port
module fetch_responder #(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_busy
);
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_data;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic          w_accept, w_rd_ok, w_wr_ok;
    assign w_accept    = i_req_valid && r_state == IDLE;
    assign w_rd_ok     = {1'b0, i_req_addr} < LIM;
    assign w_wr_ok     = {1'b0, i_wr_addr} < LIM;
    assign o_req_ready = r_state == IDLE;
    assign o_busy      = r_state != IDLE;
    assign o_rsp_valid = r_state == RESP;
    // The data/err registers keep the last word after handshake; gating forces 0 outside RESP
    assign o_rsp_data  = o_rsp_valid ? r_data : '0;
    assign o_rsp_err   = o_rsp_valid && r_err;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
            WAIT:    w_next = r_cnt == CW'(1) ? RESP : WAIT;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= w_rd_ok ? r_mem[i_req_addr] : '0;
            r_err  <= !w_rd_ok;
            r_cnt  <= CW'(WAIT_CYCLES);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
    // Memory is not reset; the read above samples the pre-write word on a same-cycle write
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
    end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: random fetch/write stimulus on three builds checked against a memory model
module tb_fetch_responder;
    logic        clk, rst;
    logic        rv [3], rr [3], we [3];
    logic [7:0]  ra [3], wa [3];
    logic [15:0] wdat [3];
    logic        rq [3], vo [3], eo [3], bo [3];
    logic [15:0] dout [3];
    logic [15:0] mem [3][256];
    int          n_chk, n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fetch_responder #(
            .DW(16), .AW(8), .DEPTH(g == 0 ? 200 : 256),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk(clk), .rst(rst),
            .i_req_valid(rv[g]), .o_req_ready(rq[g]), .i_req_addr(ra[g]),
            .o_rsp_valid(vo[g]), .i_rsp_ready(rr[g]), .o_rsp_data(dout[g]),
            .o_rsp_err(eo[g]), .i_wr_en(we[g]), .i_wr_addr(wa[g]),
            .i_wr_data(wdat[g]), .o_busy(bo[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int dep(input int k);
        return k == 0 ? 200 : 256;
    endfunction

    function automatic int wt(input int k);
        return k == 0 ? 1 : (k == 1 ? 0 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mwrite(input int k, input logic [7:0] a, input logic [15:0] d);
        if (int'(a) < dep(k)) mem[k][a] = d;
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [15:0] d);
        we[k] = 1; wa[k] = a; wdat[k] = d;
        @(negedge clk);
        we[k] = 0;
        mwrite(k, a, d);
    endtask

    task automatic check_idle(input int k);
        check("idle_valid", 32'(vo[k]), 0);
        check("idle_data", 32'(dout[k]), 0);
        check("idle_err", 32'(eo[k]), 0);
        check("idle_ready", 32'(rq[k]), 1);
        check("idle_busy", 32'(bo[k]), 0);
    endtask

    // wmode: 0 none, 1 write same address in accept cycle, 2 write it while response is held
    task automatic fetch(input int k, input logic [7:0] a, input int hold, input int wmode,
                         input logic [15:0] wd);
        logic [15:0] ed;
        logic        ee;
        int          n;
        ee = int'(a) >= dep(k);
        ed = ee ? 16'h0 : mem[k][a];
        rr[k] = hold == 0;
        check("req_ready_pre", 32'(rq[k]), 1);
        rv[k] = 1; ra[k] = a;
        if (wmode == 1) begin we[k] = 1; wa[k] = a; wdat[k] = wd; end
        @(negedge clk);
        rv[k] = 0;
        if (wmode == 1) begin we[k] = 0; mwrite(k, a, wd); end
        n = 0;
        while (vo[k] !== 1'b1 && n < 16) begin
            check("wait_data", 32'(dout[k]), 0);
            check("wait_ready", 32'(rq[k]), 0);
            check("wait_busy", 32'(bo[k]), 1);
            n++;
            @(negedge clk);
        end
        check("latency", 32'(n + 1), 32'(wt(k) + 1));
        if (n >= 16) begin
            rr[k] = 0;
            return;
        end
        check("rsp_data", 32'(dout[k]), 32'(ed));
        check("rsp_err", 32'(eo[k]), 32'(ee));
        check("rsp_busy", 32'(bo[k]), 1);
        if (wmode == 2) begin
            rr[k] = 0; we[k] = 1; wa[k] = a; wdat[k] = wd;
            @(negedge clk);
            we[k] = 0;
            mwrite(k, a, wd);
            check("rsp_after_wr", 32'(dout[k]), 32'(ed));
        end
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(vo[k]), 1);
            check("hold_data", 32'(dout[k]), 32'(ed));
            check("hold_err", 32'(eo[k]), 32'(ee));
            check("hold_ready", 32'(rq[k]), 0);
            check("hold_busy", 32'(bo[k]), 1);
        end
        rr[k] = 1;
        @(negedge clk);
        rr[k] = 0;
        check_idle(k);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 0; rr[k] = 0; we[k] = 0; ra[k] = 0; wa[k] = 0; wdat[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle(k);
        rst = 0;
        @(negedge clk);
        wr(0, 8'h00, 16'h1234);
        wr(0, 8'h01, 16'hBEEF);
        fetch(0, 8'h00, 0, 0, 16'h0);
        fetch(0, 8'h01, 5, 0, 16'h0);
        wr(0, 8'hC8, 16'hAAAA);
        fetch(0, 8'hC8, 1, 0, 16'h0);
        fetch(0, 8'hFF, 0, 0, 16'h0);
        fetch(0, 8'hC7, 0, 1, 16'h7777);
        fetch(0, 8'hC7, 0, 0, 16'h0);
        fetch(0, 8'h00, 0, 1, 16'h5555);
        fetch(0, 8'h00, 0, 0, 16'h0);
        rv[0] = 1; ra[0] = 8'h00;
        @(negedge clk);
        rv[0] = 0;
        check("rst_pre_busy", 32'(bo[0]), 1);
        #2 rst = 1;
        #1;
        check("rst_valid", 32'(vo[0]), 0);
        check("rst_busy", 32'(bo[0]), 0);
        check("rst_ready", 32'(rq[0]), 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_idle(0);
        fetch(0, 8'h01, 0, 0, 16'h0);
        for (int k = 1; k < 3; k++) begin
            wr(k, 8'h05, 16'h0A50 + 16'(k));
            fetch(k, 8'h05, 2, 0, 16'h0);
            fetch(k, 8'h05, 0, 1, 16'h1111);
            fetch(k, 8'h05, 1, 2, 16'h2222);
            fetch(k, 8'h05, 0, 0, 16'h0);
        end
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++) wr(k, 8'(a), 16'($urandom));
        for (int i = 0; i < 80; i++) begin
            int          k;
            logic [7:0]  a;
            k = int'($urandom_range(0, 2));
            a = (k == 0 && $urandom_range(0, 3) == 0) ? 8'(200 + $urandom_range(0, 55))
                                                      : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wr(k, a, 16'($urandom));
            else fetch(k, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       16'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
